// File: rtl/dlbf_pkg.sv
// Shared constants and the sliced equality compare used by the AXIS-to-RAM capture block.
package dlbf_pkg;

   localparam int GO_PIPE_STAGES = 3;
   localparam int ADDR_W         = 16;
   localparam int CNT_W          = 12;

   // Equality built from 3-bit slice compares ANDed together, so the carry-free
   // compare tree stays shallow; narrower operands are zero-extended by the caller.
   function automatic logic slice_eq(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      logic [17:0] ax;
      logic [17:0] bx;
      logic        eq;
      ax = {2'b00, a};
      bx = {2'b00, b};
      eq = 1'b1;
      for (int i = 0; i < 6; i++) begin
         eq = eq & (ax[3*i +: 3] == bx[3*i +: 3]);
      end
      return eq;
   endfunction

endpackage

// File: rtl/dlbf_data_xpm_ram.sv
// Behavioural true dual-port RAM: port A is the host (read/write, registered read
// pipeline), port B is the byte-enabled write-only stream port.
module dlbf_data_xpm_ram #(
   parameter int DATA_WIDTH       = 64,
   parameter int RAM_DEPTH        = 4096,
   parameter int RAM_READ_LATENCY = 4,
   parameter     MEM_INIT_FILE    = "none"
) (
   input  logic                          clkb,
   input  logic                          enb,
   input  logic [DATA_WIDTH/8-1:0]       web,
   input  logic [$clog2(RAM_DEPTH)-1:0]  addrb,
   input  logic [DATA_WIDTH-1:0]         dinb,
   input  logic                          clka,
   input  logic                          rsta,
   input  logic                          ena,
   input  logic [DATA_WIDTH/8-1:0]       wea,
   input  logic [$clog2(RAM_DEPTH)-1:0]  addra,
   input  logic [DATA_WIDTH-1:0]         dina,
   output logic [DATA_WIDTH-1:0]         douta
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int AW = $clog2(RAM_DEPTH);
   localparam bit HAS_INIT_FILE = (MEM_INIT_FILE != "none");

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [NB-1:0]         pa_we_q;
   logic [AW-1:0]         pa_addr_q;
   logic [DATA_WIDTH-1:0] pa_din_q;
   logic [DATA_WIDTH-1:0] rd_q [RAM_READ_LATENCY];

   // Image preload is a property of the vendor primitive; this model starts unloaded.
   logic unused_init;
   assign unused_init = HAS_INIT_FILE;

   // Host writes are posted for one bram_clk cycle and committed in the stream-clock
   // process so the array has a single writer; re-committing the same posted write
   // is idempotent when the clocks differ in rate.
   always_ff @(posedge clka) begin
      if (rsta) begin
         pa_we_q <= '0;
      end else begin
         pa_we_q <= ena ? wea : '0;
      end
      pa_addr_q <= addra;
      pa_din_q  <= dina;
   end

   always_ff @(posedge clkb) begin
      for (int b = 0; b < NB; b++) begin
         if (pa_we_q[b]) begin
            mem[pa_addr_q][8*b +: 8] <= pa_din_q[8*b +: 8];
         end
         if (enb && web[b]) begin
            mem[addrb][8*b +: 8] <= dinb[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clka) begin
      if (rsta) begin
         for (int i = 0; i < RAM_READ_LATENCY; i++) begin
            rd_q[i] <= '0;
         end
      end else begin
         if (ena) begin
            rd_q[0] <= mem[addra];
         end
         for (int i = 1; i < RAM_READ_LATENCY; i++) begin
            rd_q[i] <= rd_q[i-1];
         end
      end
   end

   assign douta = rd_q[RAM_READ_LATENCY-1];

endmodule

// File: rtl/dlbf_data_axis2ram_64b.sv
// AXI4-Stream slave that captures niter blocks of block_size beats into a dual-port
// RAM at a wrapping address, with sticky done and TLAST-misalignment flags.
module dlbf_data_axis2ram_64b
   import dlbf_pkg::*;
#(
   parameter int DATA_WIDTH       = 64,
   parameter int RAM_DEPTH        = 4096,
   parameter int RAM_READ_LATENCY = 4,
   parameter     MEM_INIT_FILE    = "none"
) (
   input  logic                    s_axis_clk,
   input  logic                    s_axis_rst,
   input  logic                    go,
   output logic                    done,
   output logic                    tlast_err,
   output logic [15:0]             addrb_wire,
   output logic [31:0]             beat_count,
   input  logic [11:0]             block_size,
   input  logic [11:0]             niter,
   input  logic [15:0]             rollover_addr,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   douta,
   input  logic [DATA_WIDTH-1:0]   dina,
   input  logic                    bram_clk,
   input  logic                    bram_rst,
   input  logic                    ena,
   input  logic [DATA_WIDTH/8-1:0] wea,
   input  logic [15:0]             addra
);

   localparam int RAM_AW = $clog2(RAM_DEPTH);

   logic [CNT_W-1:0]          block_size_minus1_q, block_size_minus1_d;
   logic [CNT_W-1:0]          niter_minus1_q, niter_minus1_d;
   logic                      niter_nz_q, niter_nz_d;
   logic [ADDR_W-1:0]         rollover_addr_minus1_q, rollover_addr_minus1_d;
   logic [GO_PIPE_STAGES-1:0] go_pipe_q, go_pipe_d;
   logic                      done_q, done_d;
   logic                      tlast_err_q, tlast_err_d;
   logic [ADDR_W-1:0]         addrb_q, addrb_d;
   logic [31:0]               beat_count_q, beat_count_d;
   logic [CNT_W-1:0]          blk_cnt_q, blk_cnt_d;
   logic [CNT_W-1:0]          iter_cnt_q, iter_cnt_d;

   logic go_int;
   logic accept;
   logic cnt_end;
   logic blk_end;
   logic last_iter;
   logic addr_wrap;
   logic unused_addra;

   assign go_int        = go_pipe_q[GO_PIPE_STAGES-1];
   assign s_axis_tready = go_int & ~done_q;
   assign unused_addra  = ^addra;

   always_comb begin
      block_size_minus1_d    = block_size - 12'd1;
      niter_minus1_d         = niter - 12'd1;
      niter_nz_d             = (niter != 12'd0);
      rollover_addr_minus1_d = rollover_addr - 16'd1;
      go_pipe_d              = {go_pipe_q[GO_PIPE_STAGES-2:0], go};

      accept    = s_axis_tvalid & s_axis_tready;
      cnt_end   = slice_eq(ADDR_W'(blk_cnt_q), ADDR_W'(block_size_minus1_q));
      // An early TLAST closes the block too, resynchronising the counter to the stream.
      blk_end   = cnt_end | s_axis_tlast;
      last_iter = slice_eq(ADDR_W'(iter_cnt_q), ADDR_W'(niter_minus1_q)) & niter_nz_q;
      addr_wrap = slice_eq(addrb_q, rollover_addr_minus1_q);

      blk_cnt_d    = blk_cnt_q;
      iter_cnt_d   = iter_cnt_q;
      addrb_d      = addrb_q;
      beat_count_d = beat_count_q;
      done_d       = done_q;
      tlast_err_d  = tlast_err_q;

      if (accept) begin
         beat_count_d = beat_count_q + 32'd1;
         addrb_d      = addr_wrap ? '0 : addrb_q + 16'd1;
         if (s_axis_tlast != cnt_end) begin
            tlast_err_d = 1'b1;
         end
         if (blk_end) begin
            blk_cnt_d  = '0;
            iter_cnt_d = iter_cnt_q + 12'd1;
            if (last_iter) begin
               done_d = 1'b1;
            end
         end else begin
            blk_cnt_d = blk_cnt_q + 12'd1;
         end
      end
   end

   always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
      if (s_axis_rst) begin
         block_size_minus1_q    <= '0;
         niter_minus1_q         <= '0;
         niter_nz_q             <= 1'b0;
         rollover_addr_minus1_q <= '0;
         go_pipe_q              <= '0;
         done_q                 <= 1'b0;
         tlast_err_q            <= 1'b0;
         addrb_q                <= '0;
         beat_count_q           <= '0;
         blk_cnt_q              <= '0;
         iter_cnt_q             <= '0;
      end else begin
         block_size_minus1_q    <= block_size_minus1_d;
         niter_minus1_q         <= niter_minus1_d;
         niter_nz_q             <= niter_nz_d;
         rollover_addr_minus1_q <= rollover_addr_minus1_d;
         go_pipe_q              <= go_pipe_d;
         done_q                 <= done_d;
         tlast_err_q            <= tlast_err_d;
         addrb_q                <= addrb_d;
         beat_count_q           <= beat_count_d;
         blk_cnt_q              <= blk_cnt_d;
         iter_cnt_q             <= iter_cnt_d;
      end
   end

   assign done       = done_q;
   assign tlast_err  = tlast_err_q;
   assign addrb_wire = addrb_q;
   assign beat_count = beat_count_q;

   dlbf_data_xpm_ram #(
      .DATA_WIDTH       (DATA_WIDTH),
      .RAM_DEPTH        (RAM_DEPTH),
      .RAM_READ_LATENCY (RAM_READ_LATENCY),
      .MEM_INIT_FILE    (MEM_INIT_FILE)
   ) u_ram (
      .clkb  (s_axis_clk),
      .enb   (accept),
      .web   (s_axis_tkeep),
      .addrb (addrb_q[RAM_AW-1:0]),
      .dinb  (s_axis_tdata),
      .clka  (bram_clk),
      .rsta  (bram_rst),
      .ena   (ena),
      .wea   (wea),
      .addra (addra[RAM_AW-1:0]),
      .dina  (dina),
      .douta (douta)
   );

endmodule

// File: tb/tb_dlbf_data_axis2ram_64b.sv
// Bench for dlbf_data_axis2ram_64b: scenario table plus hand sequences, checked against
// a beat-level model of addresses, blocks, flags and RAM contents.
module tb_dlbf_data_axis2ram_64b;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        go;
   logic        done;
   logic        tlast_err;
   logic [15:0] addrb_wire;
   logic [31:0] beat_count;
   logic [11:0] block_size;
   logic [11:0] niter;
   logic [15:0] rollover_addr;
   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic [63:0] douta;
   logic [63:0] dina;
   logic        ena;
   logic [7:0]  wea;
   logic [15:0] addra;

   dlbf_data_axis2ram_64b dut (
      .s_axis_clk    (clk),
      .s_axis_rst    (rst),
      .go            (go),
      .done          (done),
      .tlast_err     (tlast_err),
      .addrb_wire    (addrb_wire),
      .beat_count    (beat_count),
      .block_size    (block_size),
      .niter         (niter),
      .rollover_addr (rollover_addr),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .s_axis_tdata  (tdata),
      .s_axis_tkeep  (tkeep),
      .s_axis_tlast  (tlast),
      .douta         (douta),
      .dina          (dina),
      .bram_clk      (clk),
      .bram_rst      (rst),
      .ena           (ena),
      .wea           (wea),
      .addra         (addra)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   logic [63:0] m_mem [4096];
   logic [7:0]  m_bv  [4096];
   bit          m_go  [3];
   bit          m_done;
   bit          m_err;
   int          m_beats;
   int          m_pos;
   int          m_blocks;

   typedef struct {
      int bs; int ni; int ro; int nbeats; int period; int ofs; int early; int rd_words;
      int exp_beats; int exp_addr; bit exp_done; bit exp_err;
   } vec_t;
   vec_t vec [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_go[0] = 0; m_go[1] = 0; m_go[2] = 0;
      m_done = 0; m_err = 0; m_beats = 0; m_pos = 0; m_blocks = 0;
   endtask

   task automatic tick();
      m_go[2] = m_go[1];
      m_go[1] = m_go[0];
      m_go[0] = go;
      @(posedge clk);
      #1;
   endtask

   function automatic int roll_n();
      return (rollover_addr == 16'd0) ? 65536 : int'(rollover_addr);
   endfunction

   task automatic step(input bit v, input logic [63:0] d, input logic [7:0] k, input bit l, output bit acc);
      bit exp_rdy;
      bit end_by_cnt;
      int a;
      int bs;
      tvalid = v; tdata = d; tkeep = k; tlast = l;
      exp_rdy = m_go[2] && !m_done;
      check("tready", tready, exp_rdy);
      acc = v && exp_rdy;
      if (acc) begin
         bs = (block_size == 12'd0) ? 4096 : int'(block_size);
         a = (m_beats % roll_n()) % 4096;
         for (int b = 0; b < 8; b++) begin
            if (k[b]) begin
               m_mem[a][8*b +: 8] = d[8*b +: 8];
               m_bv[a][b] = 1'b1;
            end
         end
         end_by_cnt = (m_pos == bs - 1);
         if (l != end_by_cnt) m_err = 1;
         if (l || end_by_cnt) begin
            m_pos = 0;
            m_blocks++;
            if (niter != 12'd0 && m_blocks == int'(niter)) m_done = 1;
         end else begin
            m_pos++;
         end
         m_beats++;
      end
      tick();
      check("done", done, m_done);
      check("tlast_err", tlast_err, m_err);
      check("addrb_wire", addrb_wire, 64'(m_beats % roll_n()));
      check("beat_count", beat_count, 64'(m_beats));
   endtask

   task automatic do_reset();
      go = 0; tvalid = 0; tlast = 0; ena = 0; wea = '0;
      rst = 1;
      tick(); tick();
      model_reset();
      rst = 0;
      tick();
   endtask

   task automatic host_write(input int a, input logic [63:0] d);
      ena = 1; wea = 8'hFF; addra = 16'(a); dina = d;
      tick();
      ena = 0; wea = '0;
      tick();
      m_mem[a] = d;
      m_bv[a]  = 8'hFF;
   endtask

   task automatic host_read(input int a, output logic [63:0] q);
      ena = 1; wea = '0; addra = 16'(a);
      repeat (4) tick();
      q = douta;
      ena = 0;
   endtask

   task automatic verify_word(input int w);
      logic [63:0] q;
      logic [63:0] mask;
      host_read(w, q);
      for (int b = 0; b < 8; b++) mask[8*b +: 8] = m_bv[w][b] ? 8'hFF : 8'h00;
      if (mask != 64'd0) check("ram_word", q & mask, m_mem[w] & mask);
   endtask

   task automatic run_stream(input int bs, input int ni, input int ro, input int nbeats,
                             input int period, input int ofs, input int early, input int vpct,
                             input bit rnd_keep, input int pause_at);
      int idx;
      int cyc;
      bit have;
      bit v;
      bit l;
      bit acc;
      logic [63:0] d;
      logic [7:0]  k;
      block_size = 12'(bs); niter = 12'(ni); rollover_addr = 16'(ro); go = 1;
      idx = 0; cyc = 0; have = 0; v = 0; d = '0; k = 8'hFF;
      while (idx < nbeats && !m_done && cyc < 3000) begin
         if (pause_at >= 0 && cyc == pause_at) go = 0;
         if (pause_at >= 0 && cyc == pause_at + 10) go = 1;
         if (!have) begin
            d = {$urandom, $urandom};
            k = (rnd_keep && $urandom_range(0, 1) == 1) ? 8'($urandom) : 8'hFF;
            have = 1;
         end
         if (!v) v = ($urandom_range(0, 99) < vpct);
         l = (idx >= ofs && ((idx - ofs + 1) % period == 0)) || (idx == early);
         step(v, d, k, l, acc);
         if (acc) begin
            idx++; have = 0; v = 0;
         end
         cyc++;
      end
      check("stream_budget", 64'(cyc < 3000), 64'd1);
      repeat (4) step(0, '0, 8'hFF, 0, acc);
      go = 0;
      repeat (4) step(0, '0, 8'hFF, 0, acc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          n;
      logic [63:0] q;

      vec[0] = '{bs:8, ni:4, ro:64, nbeats:40, period:8, ofs:0, early:-1, rd_words:32, exp_beats:32, exp_addr:32, exp_done:1, exp_err:0};
      vec[1] = '{bs:4, ni:5, ro:10, nbeats:30, period:4, ofs:0, early:-1, rd_words:10, exp_beats:20, exp_addr:0,  exp_done:1, exp_err:0};
      vec[2] = '{bs:8, ni:2, ro:64, nbeats:30, period:8, ofs:4, early:3,  rd_words:12, exp_beats:12, exp_addr:12, exp_done:1, exp_err:1};
      vec[3] = '{bs:3, ni:3, ro:5,  nbeats:20, period:4, ofs:0, early:-1, rd_words:5,  exp_beats:7,  exp_addr:2,  exp_done:1, exp_err:1};
      vec[4] = '{bs:4, ni:0, ro:0,  nbeats:50, period:4, ofs:0, early:-1, rd_words:16, exp_beats:50, exp_addr:50, exp_done:0, exp_err:0};

      for (int i = 0; i < 4096; i++) begin
         m_mem[i] = '0; m_bv[i] = '0;
      end
      rst = 1; go = 0; tvalid = 0; tdata = '0; tkeep = '0; tlast = 0;
      block_size = '0; niter = '0; rollover_addr = '0;
      ena = 0; wea = '0; addra = '0; dina = '0;
      model_reset();

      do_reset();
      check("rst_tready", tready, 0);
      check("rst_done", done, 0);
      check("rst_tlast_err", tlast_err, 0);
      check("rst_addrb", addrb_wire, 0);
      check("rst_beat_count", beat_count, 0);

      for (int i = 0; i < 5; i++) begin
         do_reset();
         run_stream(vec[i].bs, vec[i].ni, vec[i].ro, vec[i].nbeats, vec[i].period,
                    vec[i].ofs, vec[i].early, 100, 0, -1);
         check("vec_beat_count", beat_count, 64'(vec[i].exp_beats));
         check("vec_addrb", addrb_wire, 64'(vec[i].exp_addr));
         check("vec_done", done, vec[i].exp_done);
         check("vec_tlast_err", tlast_err, vec[i].exp_err);
         for (int w = 0; w < vec[i].rd_words; w++) verify_word(w);
      end

      // Random valid gaps, random byte enables, go paused mid-capture
      do_reset();
      run_stream(5, 6, 17, 100, 5, 0, -1, 60, 1, 12);
      check("rnd_beat_count", beat_count, 64'd30);
      check("rnd_addrb", addrb_wire, 64'd13);
      check("rnd_done", done, 1);
      check("rnd_tlast_err", tlast_err, 0);
      for (int w = 0; w < 17; w++) verify_word(w);

      // Partial byte enables over a host-written word
      do_reset();
      host_write(0, 64'hFFFF_FFFF_FFFF_FFFF);
      block_size = 12'd1; niter = 12'd1; rollover_addr = 16'd0; go = 1;
      n = 0; acc = 0;
      while (!acc && n < 20) begin
         step(1, 64'h1122_3344_5566_7788, 8'h0F, 1, acc);
         n++;
      end
      check("keep_budget", 64'(acc), 64'd1);
      tvalid = 0;
      repeat (2) step(0, '0, 8'hFF, 0, acc);
      check("keep_done", done, 1);
      go = 0;
      repeat (4) step(0, '0, 8'hFF, 0, acc);
      host_read(0, q);
      check("keep_word", q, 64'hFFFF_FFFF_5566_7788);

      // Asynchronous reset mid-block, then a free-running capture from address 0
      do_reset();
      block_size = 12'd8; niter = 12'd3; rollover_addr = 16'd64; go = 1;
      n = 0; acc = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         step(1, {$urandom, $urandom}, 8'hFF, (n == 2), acc);
         if (acc) n++;
      end
      check("pre_rst_tlast_err", tlast_err, 1);
      check("pre_rst_beat_count", beat_count, 6);
      #2;
      rst = 1;
      #1;
      check("async_tready", tready, 0);
      check("async_done", done, 0);
      check("async_tlast_err", tlast_err, 0);
      check("async_addrb", addrb_wire, 0);
      check("async_beat_count", beat_count, 0);
      go = 0; tvalid = 0;
      model_reset();
      tick(); tick();
      rst = 0;
      tick();
      run_stream(4, 0, 0, 40, 4, 0, -1, 100, 0, -1);
      check("post_rst_beat_count", beat_count, 40);
      check("post_rst_addrb", addrb_wire, 40);
      check("post_rst_done", done, 0);
      for (int w = 0; w < 6; w++) verify_word(w);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
